// File: rtl/viterbi_traceback.sv
// Block-based survivor-path traceback for the 4-state (K=3, rate-1/2) Viterbi decoder.
// Optional `define VITERBI_TB_BEST_STATE_EN starts traceback from argmin(pm0..pm3) instead of state 0.
module viterbi_traceback #(
  parameter int TB_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  output logic       ready_in,
  input  logic [3:0] dec_in,
  input  logic [3:0] pm0,
  input  logic [3:0] pm1,
  input  logic [3:0] pm2,
  input  logic [3:0] pm3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last
);

  localparam int AW = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(TB_DEPTH - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACE = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          dmem [TB_DEPTH];
  logic [TB_DEPTH-1:0] obuf;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       idx;
  logic [AW-1:0]       idx_nxt;
  logic [1:0]          cur;
  logic [1:0]          start_state;
  logic                wr_en;
  logic                surv_bit;

  assign wr_en    = (state == FILL) && valid_in && ready_in;
  assign idx_nxt  = idx + 1'b1;
  assign surv_bit = dmem[rd_ptr][cur];

`ifdef VITERBI_TB_BEST_STATE_EN
  logic [3:0] best_pm;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    best_pm     = pm0;
    start_state = 2'd0;
    if (pm1 < best_pm) begin
      best_pm     = pm1;
      start_state = 2'd1;
    end
    if (pm2 < best_pm) begin
      best_pm     = pm2;
      start_state = 2'd2;
    end
    if (pm3 < best_pm) begin
      best_pm     = pm3;
      start_state = 2'd3;
    end
  end
`else
  logic unused_pm;

  assign start_state = 2'd0;
  assign unused_pm   = ^{pm0, pm1, pm2, pm3};
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      dmem[wr_ptr] <= dec_in;
    end
  end

  always_ff @(posedge clk) begin
    if (state == TRACE) begin
      obuf[rd_ptr] <= cur[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      idx       <= '0;
      cur       <= '0;
      ready_in  <= 1'b1;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST) begin
              cur      <= start_state;
              rd_ptr   <= LAST;
              ready_in <= 1'b0;
              state    <= TRACE;
            end
          end
        end
        TRACE: begin
          cur    <= {cur[0], surv_bit};
          rd_ptr <= rd_ptr - 1'b1;
          if (rd_ptr == '0) begin
            // obuf[0] is written on this same edge, so the first output bit is taken from cur directly.
            idx       <= '0;
            out_valid <= 1'b1;
            out_bit   <= cur[1];
            out_last  <= 1'b0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (idx == LAST) begin
              out_valid <= 1'b0;
              out_bit   <= 1'b0;
              out_last  <= 1'b0;
              wr_ptr    <= '0;
              ready_in  <= 1'b1;
              state     <= FILL;
            end else begin
              idx      <= idx_nxt;
              out_bit  <= obuf[idx_nxt];
              out_last <= (idx_nxt == LAST);
            end
          end
        end
        default: begin
          state     <= FILL;
          ready_in  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Scoreboard bench for viterbi_traceback (TB_DEPTH=4); honours `define VITERBI_TB_BEST_STATE_EN.
module tb_viterbi_traceback;

  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic       ready_in;
  logic [3:0] dec_in;
  logic [3:0] pm0, pm1, pm2, pm3;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;

  viterbi_traceback #(.TB_DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .dec_in    (dec_in),
    .pm0       (pm0),
    .pm1       (pm1),
    .pm2       (pm2),
    .pm3       (pm3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic [3:0] blk_dec [D];
  logic [3:0] blk_pm  [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: walk predecessors from the start state, last step first.
  function automatic int start_of();
`ifdef VITERBI_TB_BEST_STATE_EN
    int b = 0;
    for (int i = 1; i < 4; i++) if (blk_pm[i] < blk_pm[b]) b = i;
    return b;
`else
    return 0;
`endif
  endfunction

  task automatic push_model();
    int s;
    int bits [D];
    s = start_of();
    for (int t = D - 1; t >= 0; t--) begin
      bits[t] = s / 2;
      s = (s % 2) * 2 + ((int'(blk_dec[t]) >> s) & 1);
    end
    for (int t = 0; t < D; t++) q.push_back('{b: 1'(bits[t]), last: (t == D - 1)});
  endtask

  task automatic push_const(input logic [D-1:0] bits);
    for (int t = 0; t < D; t++) q.push_back('{b: bits[t], last: (t == D - 1)});
  endtask

  task automatic randomize_block();
    for (int t = 0; t < D; t++) blk_dec[t] = 4'($urandom);
    for (int i = 0; i < 4; i++) blk_pm[i] = 4'($urandom_range(0, 3));
  endtask

  task automatic send_block(input bit gaps);
    for (int t = 0; t < D; t++) begin
      int n = 0;
      while (!ready_in && n < 300) begin
        valid_in = 1'($urandom_range(0, 1));
        dec_in   = 4'b1010;
        @(posedge clk); #1;
        n++;
      end
      if (!ready_in) chk("ready_wait_timeout", 32'(ready_in), 1);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          valid_in = 1'b0;
          dec_in   = 4'($urandom);
          @(posedge clk); #1;
        end
      end
      valid_in = 1'b1;
      dec_in   = blk_dec[t];
      if (t == D - 1) begin
        pm0 = blk_pm[0]; pm1 = blk_pm[1]; pm2 = blk_pm[2]; pm3 = blk_pm[3];
      end else begin
        pm0 = 4'($urandom); pm1 = 4'($urandom); pm2 = 4'($urandom); pm3 = 4'($urandom);
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  // Cycles from the last accepted input until out_valid, with ignored writes driven meanwhile.
  task automatic measure_latency(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      valid_in = 1'($urandom_range(0, 1));
      dec_in   = 4'b1010;
      @(posedge clk); #1;
      cyc++;
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((out_valid || !ready_in) && n < 300) begin
      valid_in = 1'($urandom_range(0, 1));
      dec_in   = 4'b1010;
      @(posedge clk); #1;
      n++;
    end
    valid_in = 1'b0;
    chk("drain_ready_in", 32'(ready_in), 1);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every presented bit must match the queue head; pop only on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 0);
        end else begin
          chk("out_bit", 32'(out_bit), 32'(q[0].b));
          chk("out_last", 32'(out_last), 32'(q[0].last));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int n;
    reset = 1'b0; valid_in = 1'b0; dec_in = '0;
    pm0 = '0; pm1 = '0; pm2 = '0; pm3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_in", 32'(ready_in), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_bit", 32'(out_bit), 0);
    chk("rst_out_last", 32'(out_last), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // All-zero decisions from state 0.
    for (int t = 0; t < D; t++) blk_dec[t] = 4'b0000;
    blk_pm[0] = 4'd0; blk_pm[1] = 4'd1; blk_pm[2] = 4'd2; blk_pm[3] = 4'd3;
    push_const(4'b0000);
    send_block(1'b0);
    chk("ready_in_drop", 32'(ready_in), 0);
    measure_latency(lat);
    chk("latency", 32'(lat), D);
    n = 0;
    while (out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("emit_cycles", 32'(n), D);
    chk("ready_after_emit", 32'(ready_in), 1);

    // All-one decisions: states 0,1,3,3 -> bits 1,1,0,0 in time order.
    for (int t = 0; t < D; t++) blk_dec[t] = 4'b1111;
    push_const(4'b0011);
    send_block(1'b0);
    measure_latency(lat);
    chk("latency_b2", 32'(lat), D);
    drain();

    // Start-state selection from pm=(5,2,7,2).
    for (int t = 0; t < D; t++) blk_dec[t] = 4'b0000;
    blk_pm[0] = 4'd5; blk_pm[1] = 4'd2; blk_pm[2] = 4'd7; blk_pm[3] = 4'd2;
`ifdef VITERBI_TB_BEST_STATE_EN
    push_const(4'b0100);
`else
    push_const(4'b0000);
`endif
    send_block(1'b0);
    drain();

    // Backpressure during EMIT.
    randomize_block();
    push_model();
    send_block(1'b1);
    measure_latency(lat);
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    rdy_mode = 0;
    drain();

    // Reset asserted mid-EMIT.
    randomize_block();
    push_model();
    rdy_mode = 2;
    send_block(1'b0);
    measure_latency(lat);
    chk("pre_reset_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 0);
    chk("midreset_out_last", 32'(out_last), 0);
    chk("midreset_ready_in", 32'(ready_in), 1);
    q.delete();
    rdy_mode = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    randomize_block();
    push_model();
    send_block(1'b0);
    measure_latency(lat);
    chk("latency_post_reset", 32'(lat), D);
    drain();

    // Randomised blocks with random gaps and backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 20; k++) begin
      randomize_block();
      push_model();
      send_block(1'b1);
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
